md_iter_unit: RTL and testbench

- Iterative RV32M multiply/divide unit sitting beside the combinational ALU in the execute stage.
- Takes the same signed 32-bit operand pair A/B plus an op code, and returns result C after a fixed multi-cycle latency through a start/busy/done handshake.
- The core control stalls on busy and writes back C when done pulses.

---
 rtl/md_iter_unit.sv | 127 ++++++++++++
 tb/tb_md_iter_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/md_iter_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// one per cycle, behind a start/busy/done handshake with fixed latency.
module md_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, opnd, hi, lo;
  logic             neg_q, a_neg_q, b_zero_q, ovf_q;

  // operand conditioning at accept time
  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div = op[2];
  assign a_sgn  = is_div ? ~op[0] : (op != 3'b011);
  assign b_sgn  = is_div ? ~op[0] : ~op[1];
  assign a_neg  = a_sgn & A[WIDTH-1];
  assign b_neg  = b_sgn & B[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;

  // one iteration: hi/lo hold {partial product, multiplier} or {remainder, quotient/dividend}
  logic [WIDTH:0]   sum, rsh;
  logic [WIDTH-1:0] diff, hi_n, lo_n;
  logic             borrow, last;

  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign rsh    = {hi, lo[WIDTH-1]};
  assign borrow = rsh < {1'b0, opnd};
  assign diff   = rsh[WIDTH-1:0] - opnd;
  assign hi_n   = op_q[2] ? (borrow ? rsh[WIDTH-1:0] : diff) : sum[WIDTH:1];
  assign lo_n   = op_q[2] ? {lo[WIDTH-2:0], ~borrow} : {sum[0], lo[WIDTH-1:1]};
  assign last   = (cnt == CNT_W'(WIDTH-1));

  // result fix-up from the post-final-iteration values
  logic [2*WIDTH-1:0] p, p_s;
  logic [WIDTH-1:0]   q_s, r_s, res;

  assign p   = {hi_n, lo_n};
  assign p_s = neg_q ? -p : p;
  assign q_s = neg_q ? -lo_n : lo_n;
  assign r_s = a_neg_q ? -hi_n : hi_n;

  always_comb begin
    res = '0;
    if (!op_q[2])
      res = (op_q[1:0] == 2'b00) ? p_s[WIDTH-1:0] : p_s[2*WIDTH-1:WIDTH];
    else if (b_zero_q)
      res = op_q[1] ? a_q : '1;
    else if (ovf_q)
      res = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    else
      res = op_q[1] ? r_s : q_s;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      C        <= '0;
    end else if (state == IDLE && start) begin
      cnt      <= '0;
      op_q     <= op;
      a_q      <= A;
      hi       <= '0;
      lo       <= is_div ? a_mag : b_mag;
      opnd     <= is_div ? b_mag : a_mag;
      neg_q    <= a_neg ^ b_neg;
      a_neg_q  <= a_neg;
      b_zero_q <= (B == '0);
      ovf_q    <= is_div && !op[0] && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      hi  <= hi_n;
      lo  <= lo_n;
      if (last) C <= res;
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Randomized self-checking bench for md_iter_unit against a latency/arithmetic
// model, with literal expectations for the directed vectors.
module tb_md_iter_unit;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic [2:0]  op;
  logic [31:0] A, B, C;
  logic        busy, done;

  int errs = 0, checks = 0, cyc = 0;

  md_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .C(C)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, pr;
    int sa, sb;
    if (!o[2]) begin
      ea = (o != 3'b011) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (o <= 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      pr = ea * eb;
      return (o == 3'b000) ? pr[31:0] : pr[63:32];
    end
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      sa = a; sb = b;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? a % b : a / b;
  endfunction

  // model: phase 1..32 busy, 33 done, result appears with done and holds
  int          phase = 0;
  logic [31:0] exp_c = 0, pend = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase = 0;
      exp_c = 0;
    end else if (phase == 0) begin
      if (start) begin
        pend  = ref_calc(op, A, B);
        phase = 1;
      end
    end else if (phase == 33) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 33) exp_c = pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (phase >= 1 && phase <= 32));
    chk("done", done, (phase == 33));
    chk("C", C, exp_c);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 40) begin
      tick;
      k++;
    end
  endtask

  // issue one op; optionally inject a spurious start mid-CALC
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input bit use_lit, input bit inj);
    int k;
    tick;
    start = 1'b1; op = o; A = a; B = b;
    tick;
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    k = 1;
    while (!done && k < 40) begin
      if (inj && k == 5) start = 1'b1;
      if (inj && k == 6) start = 1'b0;
      tick;
      k++;
    end
    start = 1'b0;
    chk("latency", k, 33);
    if (use_lit) chk("directed_C", C, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k, t0, t1;
    rstn = 1'b0; start = 1'b0; op = 3'd0; A = 0; B = 0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_C", C, 0);
    tick;
    rstn = 1'b1;

    run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 0);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0);
    run(3'b101, 32'd100, 32'd7, 32'd14, 1, 0);
    run(3'b111, 32'd100, 32'd7, 32'd2, 1, 0);
    run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run(3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    run(3'b000, 32'd6, 32'd9, 32'd54, 1, 1);

    // start held high across done: second op accepted after one idle cycle
    tick;
    start = 1'b1; op = 3'b101; A = 32'd1000; B = 32'd10;
    tick;
    wait_done(k);
    chk("b2b_first", C, 32'd100);
    t0 = cyc;
    op = 3'b000; A = 32'd12; B = 32'd12;
    tick;
    tick;
    start = 1'b0;
    wait_done(k);
    t1 = cyc;
    chk("b2b_second", C, 32'd144);
    chk("b2b_spacing", t1 - t0, 34);

    // reset in the middle of CALC
    tick;
    start = 1'b1; op = 3'b011; A = $urandom; B = $urandom;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_C", C, 0);
    repeat (3) tick;
    rstn = 1'b1;
    repeat (40) tick;
    run(3'b001, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1, 0);

    for (int i = 0; i < 40; i++)
      run(3'($urandom_range(0, 7)), pick(), pick(), 32'h0, 0, (i % 7 == 0));

    tick;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

endmodule
